// File: rtl/simon_key_schedule.sv
// SIMON key expansion engine: loads an M-word master key, generates T round keys
// one per cycle into a local store, then serves reads by round index with one cycle of latency.
module simon_key_schedule #(
  parameter int N = 48,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*M-1:0] key,
  input  logic [6:0]     i,
  output logic [N-1:0]   key_i,
  output logic           ready
);

  function automatic int calc_t(int n, int m);
    case (n)
      16:      return 32;
      24:      return 36;
      32:      return (m == 3) ? 42 : 44;
      48:      return (m == 2) ? 52 : 54;
      default: return (m == 2) ? 68 : (m == 3) ? 69 : 72;
    endcase
  endfunction

  function automatic int calc_zsel(int n, int m);
    case (n)
      16:      return 0;
      24:      return (m == 3) ? 0 : 1;
      32:      return (m == 3) ? 2 : 3;
      48:      return (m == 2) ? 2 : 3;
      default: return (m == 2) ? 2 : (m == 3) ? 3 : 4;
    endcase
  endfunction

  // Literals are written leftmost-first; the result is flipped so bit j is sequence element j.
  function automatic logic [61:0] zseq(int s);
    logic [61:0] z, r;
    case (s)
      0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       z = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: z = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
    for (int j = 0; j < 62; j++) r[j] = z[61-j];
    return r;
  endfunction

  localparam int          T    = calc_t(N, M);
  localparam int          ZSEL = calc_zsel(N, M);
  localparam int          AW   = $clog2(T);
  localparam logic [61:0] Z    = zseq(ZSEL);

  function automatic logic [N-1:0] ror(logic [N-1:0] x, int r);
    return (x >> r) | (x << (N - r));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state;
  logic [N-1:0]        ks [T];
  logic [M-1:0][N-1:0] win;   // win[0] = k[cnt-M] ... win[M-1] = k[cnt-1]
  logic [6:0]          cnt;
  logic [5:0]          zidx;
  logic [N-1:0]        a, tmp, nk;

  assign a   = ror(win[M-1], 3) ^ ((M == 4) ? win[1] : '0);
  assign tmp = a ^ ror(a, 1);
  // XOR with the z bit and 3 collapses to: bit1 flipped, bit0 flipped unless z is set.
  assign nk  = ~win[0] ^ tmp ^ {{(N-2){1'b0}}, 1'b1, ~Z[zidx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ready <= 1'b0;
      key_i <= '0;
      cnt   <= '0;
      zidx  <= '0;
    end else begin
      key_i <= (ready && !start && i < 7'(T)) ? ks[i[AW-1:0]] : '0;
      case (state)
        S_BUSY: begin
          if (cnt == 7'(T)) begin
            state <= S_DONE;
            ready <= 1'b1;
          end else begin
            ks[cnt[AW-1:0]] <= nk;
            win  <= {nk, win[M-1:1]};
            cnt  <= cnt + 7'd1;
            zidx <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
          end
        end
        default: begin
          if (start) begin
            state <= S_BUSY;
            ready <= 1'b0;
            cnt   <= 7'(M);
            zidx  <= '0;
            win   <= key;
            for (int j = 0; j < M; j++) ks[j] <= key[j*N +: N];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench: 48/2 engine for timing, restart, reset and read behaviour,
// plus 16/4, 32/3 and 64/4 instances checked against a software key-schedule model.
module tb_simon_key_schedule;

  logic        clk, rst, start;
  logic [6:0]  i;
  logic [95:0] k48;
  logic [63:0] k16;
  logic [95:0] k32;
  logic [255:0] k64;
  logic [47:0] q48;
  logic [15:0] q16;
  logic [31:0] q32;
  logic [63:0] q64;
  logic        r48, r16, r32, r64;

  int ncmp = 0, nerr = 0;
  logic [63:0] ek [72];
  logic [61:0] zt [5];

  simon_key_schedule #(.N(48), .M(2)) u48 (.clk(clk), .rst(rst), .start(start), .key(k48),
    .i(i), .key_i(q48), .ready(r48));
  simon_key_schedule #(.N(16), .M(4)) u16 (.clk(clk), .rst(rst), .start(start), .key(k16),
    .i(i), .key_i(q16), .ready(r16));
  simon_key_schedule #(.N(32), .M(3)) u32 (.clk(clk), .rst(rst), .start(start), .key(k32),
    .i(i), .key_i(q32), .ready(r32));
  simon_key_schedule #(.N(64), .M(4)) u64 (.clk(clk), .rst(rst), .start(start), .key(k64),
    .i(i), .key_i(q64), .ready(r64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    logic [63:0] msk;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & msk;
  endfunction

  task automatic gen(input int n, input int m, input int t, input int zs, input logic [255:0] key);
    logic [63:0] msk, tmp;
    logic zb;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int j = 0; j < m; j++) ek[j] = 64'(key >> (j * n)) & msk;
    for (int c = m; c < t; c++) begin
      tmp = ror(ek[c-1], 3, n);
      if (m == 4) tmp = tmp ^ ek[c-3];
      tmp = tmp ^ ror(tmp, 1, n);
      zb = zt[zs][61 - ((c - m) % 62)];
      ek[c] = (~ek[c-m] ^ tmp ^ 64'(zb) ^ 64'd3) & msk;
    end
  endtask

  function automatic logic [63:0] q(input int d);
    case (d)
      0:       return 64'(q48);
      1:       return 64'(q16);
      2:       return 64'(q32);
      default: return q64;
    endcase
  endfunction

  task automatic sweep(input int d, input int t, input string tag);
    for (int j = 0; j < t; j++) begin
      i = 7'(j);
      tick();
      chk($sformatf("%s[%0d]", tag, j), q(d), ek[j]);
    end
  endtask

  // Counts edges after the start edge until ready, bounded.
  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (!r48 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [95:0] key1, keys;
    zt[0] = 62'b11111010001001010110000111001101111101000100101011000011100110;
    zt[1] = 62'b10001110111110010011000010110101000111011111001001100001011010;
    zt[2] = 62'b10101111011100000011010010011000101000010001111110010110110011;
    zt[3] = 62'b11011011101011000110010111100000010010001010011100110100001111;
    zt[4] = 62'b11010001111001101011011000100000010111000011001010010011101111;
    key1 = {48'h1211100A09, 48'h08020100E0};
    keys = {48'h0d0c0b0a0908, 48'h050403020100};
    rst = 1'b1; start = 1'b0; i = '0;
    k48 = key1; k16 = 64'h1918111009080100;
    k32 = 96'h131211100b0a090803020100;
    k64 = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 64'(r48), 64'd0);
    chk("rst_key_i", 64'(q48), 64'd0);

    // first key: low words come straight from the master key
    start = 1'b1; tick(); start = 1'b0;
    wait_rdy(0, n);
    chk("t1_lat", 64'(n), 64'd51);
    i = 7'd0; tick();
    chk("t1_k0", 64'(q48), 64'h0008020100E0);
    i = 7'd1; tick();
    chk("t1_k1", 64'(q48), 64'h001211100A09);

    // restart while ready with the SIMON96/96 key; read in the start cycle is 0
    k48 = keys; start = 1'b1; tick(); start = 1'b0;
    chk("t2_rd_on_start", 64'(q48), 64'd0);
    chk("t2_ready_drop", 64'(r48), 64'd0);
    for (int j = 0; j < 10; j++) tick();
    chk("t2_rd_busy", 64'(q48), 64'd0);
    wait_rdy(10, n);
    chk("t2_lat", 64'(n), 64'd51);
    i = 7'd2; tick();
    chk("t2_k2", 64'(q48), 64'h7B8ABD2C1F4C);
    gen(48, 2, 52, 2, 256'(keys));
    sweep(0, 52, "sw96");
    i = 7'd52; tick();
    chk("t2_i52", 64'(q48), 64'd0);
    i = 7'd127; tick();
    chk("t2_i127", 64'(q48), 64'd0);

    // start pulse during expansion is ignored
    k48 = key1; start = 1'b1; tick(); start = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    k48 = keys; start = 1'b1; tick(); start = 1'b0;
    wait_rdy(11, n);
    chk("t3_lat", 64'(n), 64'd51);
    gen(48, 2, 52, 2, 256'(key1));
    sweep(0, 52, "swk1");

    // reset mid-expansion aborts; engine stays idle
    start = 1'b1; tick(); start = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_ready", 64'(r48), 64'd0);
    chk("t4_key_i", 64'(q48), 64'd0);
    i = 7'd0;
    for (int j = 0; j < 60; j++) tick();
    chk("t4_idle_ready", 64'(r48), 64'd0);
    chk("t4_idle_key_i", 64'(q48), 64'd0);

    // other geometries
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(r16 && r32 && r64) && n < 200) begin
      tick();
      n++;
    end
    chk("p_ready", {61'd0, r16, r32, r64}, 64'd7);
    gen(16, 4, 32, 0, 256'(k16));
    sweep(1, 32, "sw16");
    gen(32, 3, 42, 2, 256'(k32));
    sweep(2, 42, "sw32");
    gen(64, 4, 72, 4, k64);
    sweep(3, 72, "sw64");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
